// File: rtl/toe_lookup_arb_if.sv
// Bundle between the lookup arbiter and its two requesters and the searcher.
// slave  : the arbiter's view (requests, searcher results in; ready, response, searcher command out)
// master : the environment's view (the reverse)
interface toe_lookup_arb_if #(
   parameter int ID_W = 7
);
   logic            req0_valid;
   logic [191:0]    req0_tuple;
   logic            req0_ready;
   logic            req1_valid;
   logic [191:0]    req1_tuple;
   logic            req1_ready;
   logic            rsp_valid;
   logic            rsp_grant;
   logic [ID_W-1:0] rsp_id;
   logic            rsp_error;
   logic            rsp_timeout;
   logic            ENABLE;
   logic [47:0]     src_mac;
   logic [47:0]     dst_mac;
   logic [31:0]     src_ip;
   logic [31:0]     dst_ip;
   logic [15:0]     src_port;
   logic [15:0]     dst_port;
   logic            DONE;
   logic            ERROR;
   logic [ID_W-1:0] ID;

   modport slave (
      input  req0_valid, req0_tuple, req1_valid, req1_tuple, DONE, ERROR, ID,
      output req0_ready, req1_ready, rsp_valid, rsp_grant, rsp_id, rsp_error, rsp_timeout,
      output ENABLE, src_mac, dst_mac, src_ip, dst_ip, src_port, dst_port
   );

   modport master (
      output req0_valid, req0_tuple, req1_valid, req1_tuple, DONE, ERROR, ID,
      input  req0_ready, req1_ready, rsp_valid, rsp_grant, rsp_id, rsp_error, rsp_timeout,
      input  ENABLE, src_mac, dst_mac, src_ip, dst_ip, src_port, dst_port
   );
endinterface

// File: rtl/toe_lookup_arb.sv
// Round-robin arbiter in front of a single connection-table searcher.
// One lookup is in flight at a time; WAIT is bounded by TIMEOUT cycles.
//
// state | meaning
// IDLE  | offer ready to the round-robin winner, latch tuple on accept
// ISSUE | one-cycle ENABLE pulse to the searcher, clear wait counter
// WAIT  | sample DONE/ERROR each cycle, abort after TIMEOUT cycles
// RESP  | one-cycle rsp_valid strobe, then back to IDLE
module toe_lookup_arb #(
   parameter int TIMEOUT = 255,
   parameter int ID_W    = 7
) (
   input logic             clk,
   input logic             RESET_n,
   toe_lookup_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t          state_q, state_d;
   logic            last_q, last_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [191:0]    tuple_q, tuple_d;
   logic            grant_q, grant_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            err_q, err_d;
   logic            tmo_q, tmo_d;
   logic            rdy0, rdy1;
   logic            win;

   // Next-state, arbitration and response capture.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      tuple_d = tuple_q;
      grant_d = grant_q;
      id_d    = id_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      rdy0    = 1'b0;
      rdy1    = 1'b0;
      win     = 1'b0;
      case (state_q)
         IDLE: begin
            // Tie goes to whichever requester was not granted last.
            if (bus.req0_valid && bus.req1_valid) win = ~last_q;
            else                                  win = bus.req1_valid;
            // Ready is held low while reset is asserted even though the FSM sits in IDLE.
            if (RESET_n && (bus.req0_valid || bus.req1_valid)) begin
               rdy0    = ~win;
               rdy1    = win;
               tuple_d = win ? bus.req1_tuple : bus.req0_tuple;
               grant_d = win;
               last_d  = win;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.ERROR) begin
               id_d    = '0;
               err_d   = 1'b1;
               tmo_d   = 1'b0;
               state_d = RESP;
            end else if (bus.DONE) begin
               id_d    = bus.ID;
               err_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = RESP;
            end else begin
               // WAIT therefore lasts at most TIMEOUT cycles.
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TMO) begin
                  id_d    = '0;
                  err_d   = 1'b1;
                  tmo_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any lookup in flight.
   always_ff @(posedge clk or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= 8'd0;
         tuple_q <= '0;
         grant_q <= 1'b0;
         id_q    <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         tuple_q <= tuple_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.req0_ready  = rdy0;
   assign bus.req1_ready  = rdy1;
   assign bus.ENABLE      = (state_q == ISSUE);
   assign bus.rsp_valid   = (state_q == RESP);
   assign bus.rsp_grant   = grant_q;
   assign bus.rsp_id      = id_q;
   assign bus.rsp_error   = err_q;
   assign bus.rsp_timeout = tmo_q;
   assign bus.src_mac     = tuple_q[191:144];
   assign bus.dst_mac     = tuple_q[143:96];
   assign bus.src_ip      = tuple_q[95:64];
   assign bus.dst_ip      = tuple_q[63:32];
   assign bus.src_port    = tuple_q[31:16];
   assign bus.dst_port    = tuple_q[15:0];

endmodule
